// File: rtl/pipeline_div.sv
// pipeline_div: iterative restoring divider, one quotient bit per clock.
// Divides a 2*WIDTH-bit dividend by a WIDTH-bit divisor, giving a WIDTH-bit
// quotient and remainder. Divide-by-zero and quotient overflow are caught
// when the operation is accepted and complete early without entering CALC.
//
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-high reset
//   start             request, accepted only in IDLE or DONE
//   dividend, divisor operands, captured on the accepted start
//   busy              high while iterating
//   done              one-cycle completion pulse
//   quot, rem         results, held until the next done
//   div_by_zero       last completed operation had divisor == 0
//   overflow          last completed operation's quotient exceeded WIDTH bits
module pipeline_div #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quot,
    output logic [WIDTH-1:0]     rem,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // StExc is the single non-busy cycle between accepting an exceptional
    // operation and reporting it in StDone.
    typedef enum logic [1:0] {StIdle, StCalc, StExc, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  r_q, r_d;      // partial remainder
    logic [WIDTH-1:0]  q_q, q_d;      // quotient shift register
    logic [WIDTH-1:0]  dvs_q, dvs_d;  // latched divisor
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              dbz_q, dbz_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic              pre_exc;
    logic              last_iter;
    logic [WIDTH:0]    s;
    logic              ge;
    logic [WIDTH-1:0]  r_step;
    logic [WIDTH-1:0]  q_step;

    assign accept    = start && ((state_q == StIdle) || (state_q == StDone));
    assign pre_exc   = (divisor == '0) || (dividend[2*WIDTH-1:WIDTH] >= divisor);
    assign last_iter = (cnt_q == CntW'(WIDTH - 1));

    // One restoring step. S is WIDTH+1 bits so the bit shifted out of R is kept
    // for the compare; when S >= divisor the difference is below the divisor,
    // so a WIDTH-bit subtraction of the low bits gives it exactly.
    assign s      = {r_q, q_q[WIDTH-1]};
    assign ge     = (s >= {1'b0, dvs_q});
    assign r_step = ge ? (s[WIDTH-1:0] - dvs_q) : s[WIDTH-1:0];
    assign q_step = {q_q[WIDTH-2:0], ge};

    // State register and all datapath flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = pre_exc ? StExc : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            StCalc: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StExc:   state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dbz_d  = dbz_q;
        ovf_d  = ovf_q;
        if (accept) begin
            r_d   = dividend[2*WIDTH-1:WIDTH];
            q_d   = dividend[WIDTH-1:0];
            dvs_d = divisor;
            cnt_d = '0;
            dbz_d = 1'b0;
            ovf_d = 1'b0;
        end else begin
            unique case (state_q)
                StCalc: begin
                    r_d   = r_step;
                    q_d   = q_step;
                    cnt_d = cnt_q + CntW'(1);
                    if (last_iter) begin
                        quot_d = q_step;
                        rem_d  = r_step;
                    end
                end
                StExc: begin
                    // q_q still holds the low half of the dividend here.
                    quot_d = '1;
                    rem_d  = q_q;
                    dbz_d  = (dvs_q == '0);
                    ovf_d  = (dvs_q != '0);
                end
                default: ;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        busy        = (state_q == StCalc);
        done        = (state_q == StDone);
        quot        = quot_q;
        rem         = rem_q;
        div_by_zero = dbz_q;
        overflow    = ovf_q;
    end

endmodule

// File: tb/tb_pipeline_div.sv
// tb_pipeline_div: self-checking bench for pipeline_div (WIDTH=64). Results are
// compared against plain 128-bit division in the bench plus the exception rules.
module tb_pipeline_div;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  dividend = '0;
    logic [63:0]   divisor = '0;
    logic          busy;
    logic          done;
    logic [63:0]   quot;
    logic [63:0]   rem;
    logic          div_by_zero;
    logic          overflow;

    int n_checks = 0;
    int n_bad = 0;

    pipeline_div #(.WIDTH(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quot        (quot),
        .rem         (rem),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what a divider must return for these operands.
    task automatic model(input logic [127:0] a, input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic dbz, output logic ovf);
        logic [127:0] qq, rr;
        dbz = 1'b0;
        ovf = 1'b0;
        if (b == 0) begin
            dbz = 1'b1;
            q   = '1;
            r   = a[63:0];
        end else if (a[127:64] >= b) begin
            ovf = 1'b1;
            q   = '1;
            r   = a[63:0];
        end else begin
            qq = a / {64'd0, b};
            rr = a % {64'd0, b};
            q  = qq[63:0];
            r  = rr[63:0];
        end
    endtask

    // Called just after an accepting edge; counts cycles until done is seen.
    // With glitch set, start pulses with other operands mid-operation.
    task automatic wait_done(input string tag, input bit glitch,
                             output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy) bcnt++;
            if (cyc == 1) check_val({tag, "_flags_clr"}, {div_by_zero, overflow}, 0);
            if (glitch && cyc == 9) begin
                start    = 1'b1;
                dividend = 128'd5000;
                divisor  = 64'd3;
            end
            if (glitch && cyc == 10) start = 1'b0;
        end while (!done && cyc < 200);
        check_val({tag, "_done_seen"}, done, 1);
    endtask

    task automatic check_result(input string tag, input logic [127:0] a,
                                input logic [63:0] b, input int cyc, input int bcnt);
        logic [63:0] eq, er;
        logic        edz, eov;
        model(a, b, eq, er, edz, eov);
        check_val({tag, "_latency"}, cyc, (edz || eov) ? 2 : 65);
        check_val({tag, "_busy_cycles"}, bcnt, (edz || eov) ? 0 : 64);
        check_val({tag, "_quot"}, quot, eq);
        check_val({tag, "_rem"}, rem, er);
        check_val({tag, "_dbz"}, div_by_zero, edz);
        check_val({tag, "_ovf"}, overflow, eov);
    endtask

    task automatic run_op(input string tag, input logic [127:0] a, input logic [63:0] b,
                          input bit glitch);
        int cyc, bcnt;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = {$urandom, $urandom, $urandom, $urandom};
        divisor  = {$urandom, $urandom};
        wait_done(tag, glitch, cyc, bcnt);
        check_result(tag, a, b, cyc, bcnt);
        @(negedge clk);
        check_val({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int cyc, bcnt;
        logic [63:0] b, hi;
        logic [127:0] a;
        bit seen;

        #1 reset = 1'b1;
        #2;
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_quot", quot, 0);
        check_val("rst_rem", rem, 0);
        check_val("rst_flags", {div_by_zero, overflow}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        run_op("d100_7", 128'd100, 64'd7, 1'b0);
        run_op("mul_inv", 128'hFFFFFFFFFFFFFFFE_0000000000000001, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        run_op("pow2", {64'h1, 64'h0}, 64'h2, 1'b0);
        run_op("msb", {64'h7FFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF}, 64'h8000000000000000,
               1'b0);
        run_op("dbz", 128'h1234, 64'h0, 1'b0);
        run_op("ovf", {64'h5, 64'h9}, 64'h5, 1'b0);
        run_op("glitch", 128'd100, 64'd7, 1'b1);

        // Start held high: second op accepted on the DONE cycle.
        @(negedge clk);
        dividend = 128'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 128'hABCDEF_0123456789;
        divisor  = 64'd1000003;
        wait_done("held1", 1'b0, cyc, bcnt);
        check_result("held1", 128'd100, 64'd7, cyc, bcnt);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("held2", 1'b0, cyc, bcnt);
        check_result("held2", 128'hABCDEF_0123456789, 64'd1000003, cyc, bcnt);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        dividend = 128'd100;
        divisor  = 64'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (29) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_quot", quot, 0);
        check_val("mid_rst_rem", rem, 0);
        check_val("mid_rst_flags", {div_by_zero, overflow}, 0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("mid_rst_no_done", seen, 0);
        run_op("after_rst", 128'd100, 64'd7, 1'b0);

        // Randomized operations across normal and exceptional cases.
        for (int i = 0; i < 24; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            b    = {$urandom, $urandom};
            hi   = {$urandom, $urandom};
            if (mode == 2) b = 64'($urandom_range(1, 1000));
            if (mode == 3) b = b | 64'h8000000000000000;
            if (mode == 0) begin
                b = '0;
            end else if (mode == 1) begin
                hi = b;
            end else begin
                if (b == 0) b = 64'd1;
                hi = hi % b;
            end
            a = {hi, $urandom, $urandom};
            run_op($sformatf("rnd%0d", i), a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
